fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and load-use hazard controller for the pipelined MIPS datapath. It tracks in-flight register writers across a configurable number of post-decode stages and, for each decode-stage source operand, selects the youngest forwarding source. When a source depends on a load whose data is not yet available, it stalls decode and inserts a bubble. It generalises the fixed two-operand EX/MEM forwarding selects to N operands and N stages, and adds stall generation plus a stall counter.

---
 rtl/fwd_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
// Forwarding-select and load-use hazard controller for the pipelined MIPS
// datapath. A DEPTH-entry shift register mirrors the register writers that
// sit in the stages after ID. For every decode-stage source operand it picks
// the youngest in-flight producer of that register. If that producer is a
// load whose data is not ready yet, decode is stalled and a bubble is issued.
module fwd_hazard_ctrl #(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    localparam int SELW      = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [NUM_SRC*AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]      id_src_used,
    input  logic [AW-1:0]           id_dst,
    input  logic                    id_regwr,
    input  logic                    id_load,
    input  logic                    flush,
    output logic [NUM_SRC*SELW-1:0] fwd_sel,
    output logic                    stall,
    output logic                    bubble,
    output logic [CNT_W-1:0]        stall_cnt
);

    // Tracking entries: index k is the instruction currently in stage k
    logic [DEPTH:1]   st_valid;
    logic [DEPTH:1]   st_regwr;
    logic [DEPTH:1]   st_load;
    logic [AW-1:0]    st_dst [1:DEPTH];

    logic [DEPTH:1]   producer;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] matched;
    logic [NUM_SRC-1:0] hazard;

    // An entry can forward only if it really writes a register other than r0
    always_comb begin
        producer = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            producer[k] = st_valid[k] & st_regwr[k] & (st_dst[k] != '0);
        end
    end

    // An operand takes part only when ID holds a live, unflushed reader of it
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = id_valid & id_src_used[i] & ~flush;
        end
    end

    // Scan from stage 1 outward and keep the first hit, so the youngest producer wins
    always_comb begin
        fwd_sel = '0;
        matched = '0;
        hazard  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (!matched[i] && eligible[i] && producer[k] &&
                    (st_dst[k] == id_src[i*AW +: AW])) begin
                    matched[i]              = 1'b1;
                    fwd_sel[i*SELW +: SELW] = SELW'(k);
                    hazard[i]               = st_load[k] && (k < LOAD_READY);
                end
            end
        end
    end

    assign stall  = |hazard;
    assign bubble = stall;

    // Advance the tracking pipe; stalled or flushed decode slots enter as invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_valid <= '0;
            st_regwr <= '0;
            st_load  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                st_dst[k] <= '0;
            end
        end else begin
            st_valid[1] <= id_valid & ~flush & ~stall;
            st_dst[1]   <= id_dst;
            st_regwr[1] <= id_regwr;
            st_load[1]  <= id_load;
            for (int k = 2; k <= DEPTH; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_dst[k]   <= st_dst[k-1];
                st_regwr[k] <= st_regwr[k-1];
                st_load[k]  <= st_load[k-1];
            end
        end
    end

    // Count stalled cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl
// Directed bench for fwd_hazard_ctrl. Three instances share clock and reset:
// the default configuration, a copy with a 2-bit stall counter fed the same
// stimulus, and a DEPTH=3 / LOAD_READY=3 / NUM_SRC=3 copy with its own inputs.
module tb_fwd_hazard_ctrl;

    localparam int AW = 5;

    logic clk;
    logic rst;

    // Default-configuration inputs (also feed the small-counter instance)
    logic          id_valid;
    logic [2*AW-1:0] id_src;
    logic [1:0]    id_src_used;
    logic [AW-1:0] id_dst;
    logic          id_regwr;
    logic          id_load;
    logic          flush;

    logic [3:0]    fwd_sel;
    logic          stall;
    logic          bubble;
    logic [15:0]   stall_cnt;

    logic [3:0]    sat_fwd_sel;
    logic          sat_stall;
    logic          sat_bubble;
    logic [1:0]    sat_cnt;

    // Deep-configuration inputs and outputs
    logic          d_valid;
    logic [3*AW-1:0] d_src;
    logic [2:0]    d_used;
    logic [AW-1:0] d_dst;
    logic          d_regwr;
    logic          d_load;
    logic          d_flush;

    logic [5:0]    d_fwd_sel;
    logic          d_stall;
    logic          d_bubble;
    logic [15:0]   d_cnt;

    int vectors;
    int miscompares;

    fwd_hazard_ctrl u_dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_dst(id_dst), .id_regwr(id_regwr), .id_load(id_load), .flush(flush),
        .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
    );

    fwd_hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_dst(id_dst), .id_regwr(id_regwr), .id_load(id_load), .flush(flush),
        .fwd_sel(sat_fwd_sel), .stall(sat_stall), .bubble(sat_bubble), .stall_cnt(sat_cnt)
    );

    fwd_hazard_ctrl #(.NUM_SRC(3), .DEPTH(3), .LOAD_READY(3)) u_deep (
        .clk(clk), .rst(rst),
        .id_valid(d_valid), .id_src(d_src), .id_src_used(d_used),
        .id_dst(d_dst), .id_regwr(d_regwr), .id_load(d_load), .flush(d_flush),
        .fwd_sel(d_fwd_sel), .stall(d_stall), .bubble(d_bubble), .stall_cnt(d_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [1:0] used, input logic [AW-1:0] dst,
                         input logic wr, input logic ld, input logic fl);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_dst      = dst;
        id_regwr    = wr;
        id_load     = ld;
        flush       = fl;
    endtask

    task automatic d_drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                           input logic [AW-1:0] s2, input logic [2:0] used,
                           input logic [AW-1:0] dst, input logic wr, input logic ld);
        d_valid = v;
        d_src   = {s2, s1, s0};
        d_used  = used;
        d_dst   = dst;
        d_regwr = wr;
        d_load  = ld;
        d_flush = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fwd_sel !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_sel_async: got %0h expected 0", fwd_sel);
        end
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_stall_async: got %0b expected 0", stall);
        end
        vectors++;
        if (stall_cnt !== 16'd0 || sat_cnt !== 2'd0 || d_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", stall_cnt, sat_cnt, d_cnt);
        end
        step();
        vectors++;
        if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_held: got sel=%0h stall=%0b expected sel=0 stall=0", fwd_sel, stall);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got sel=%0h stall=%0b expected sel=0 stall=0", fwd_sel, stall);
        end
        step();
        drain();
    endtask

    task automatic test_ex_mem_forward();
        // add r3, add r4, sub r5 = r3 - r4
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fwd_sel !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL exmem_unrelated: got %0h expected 0", fwd_sel);
        end
        step();
        drive(1'b1, 5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fwd_sel !== 4'b0110) begin
            miscompares++;
            $display("[TB] FAIL exmem_sel: got %0h expected 6", fwd_sel);
        end
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL exmem_stall: got %0b expected 0", stall);
        end
        step();
        drain();
        // Writers to r0 are never forwarded
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL r0_sel: got sel=%0h stall=%0b expected sel=0 stall=0", fwd_sel, stall);
        end
        step();
        drain();
    endtask

    task automatic test_priority();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd3, 5'd3, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fwd_sel !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL priority_sel: got %0h expected 5", fwd_sel);
        end
        step();
        drain();
    endtask

    task automatic test_load_use();
        // lw r7 ; add r8 = r7 + r1
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd7, 5'd1, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (stall !== 1'b1 || bubble !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL loaduse_stall: got stall=%0b bubble=%0b expected 1/1", stall, bubble);
        end
        step();
        #1;
        vectors++;
        if (stall_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL loaduse_cnt: got %0d expected 1", stall_cnt);
        end
        vectors++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL loaduse_release: got stall=%0b bubble=%0b expected 0/0", stall, bubble);
        end
        vectors++;
        if (fwd_sel !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL loaduse_sel: got %0h expected 2", fwd_sel);
        end
        step();
        drain();
        // Same sequence but the r7 operand is not actually read
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd7, 5'd1, 2'b10, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (stall !== 1'b0 || fwd_sel !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL unused_operand: got stall=%0b sel=%0h expected 0/0", stall, fwd_sel);
        end
        step();
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        // Flushed reader of r7 that would also write r9
        drive(1'b1, 5'd7, 5'd1, 2'b01, 5'd9, 1'b1, 1'b0, 1'b1);
        #1;
        vectors++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_stall: got stall=%0b bubble=%0b expected 0/0", stall, bubble);
        end
        step();
        drive(1'b1, 5'd9, 5'd7, 2'b11, 5'd10, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (fwd_sel !== 4'b1000 || stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_entry: got sel=%0h stall=%0b expected sel=8 stall=0", fwd_sel, stall);
        end
        step();
        drain();
    endtask

    task automatic test_saturation();
        // One stall has already been counted; five more must pin the 2-bit counter at 3
        for (int n = 0; n < 5; n++) begin
            drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
            step();
            drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
            #1;
            vectors++;
            if (sat_stall !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL sat_stall_%0d: got %0b expected 1", n, sat_stall);
            end
            step();
            idle();
            step();
        end
        vectors++;
        if (sat_cnt !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL sat_cnt: got %0d expected 3", sat_cnt);
        end
        vectors++;
        if (stall_cnt !== 16'd6) begin
            miscompares++;
            $display("[TB] FAIL wide_cnt: got %0d expected 6", stall_cnt);
        end
        drain();
    endtask

    task automatic test_deep_load_use();
        // lw r9 followed immediately by a reader of r9 in operand 2
        d_drive(1'b1, 5'd1, 5'd0, 5'd0, 3'b001, 5'd9, 1'b1, 1'b1);
        step();
        d_drive(1'b1, 5'd1, 5'd2, 5'd9, 3'b111, 5'd11, 1'b1, 1'b0);
        #1;
        vectors++;
        if (d_stall !== 1'b1 || d_bubble !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL deep_stall1: got stall=%0b bubble=%0b expected 1/1", d_stall, d_bubble);
        end
        step();
        #1;
        vectors++;
        if (d_stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL deep_stall2: got %0b expected 1", d_stall);
        end
        step();
        #1;
        vectors++;
        if (d_stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL deep_release: got %0b expected 0", d_stall);
        end
        vectors++;
        if (d_fwd_sel !== 6'b110000) begin
            miscompares++;
            $display("[TB] FAIL deep_sel: got %0h expected 30", d_fwd_sel);
        end
        vectors++;
        if (d_cnt !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL deep_cnt: got %0d expected 2", d_cnt);
        end
        step();
        d_drive(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0);
        step();
    endtask

    // Sequence the scenarios and report
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        idle();
        d_drive(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();

        test_reset();
        test_ex_mem_forward();
        test_priority();
        test_load_use();
        test_flush();
        test_saturation();
        test_deep_load_use();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
